// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the x^24+x^23+x^22+x^17+1 LFSR stream: locks,
// flywheels its own prediction, counts bit errors and re-emits completed words.
// state  | meaning
// SEARCH | filling the 24-bit window from the received stream
// VERIFY | window self-synchronising; counting consecutive correct predictions
// LOCKED | flywheel on prediction; counting errors, emitting words every 24 bits
module lfsr_seq_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic [23:0]      word_out,
    output logic             word_valid
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_M1 = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_M1 = 4'(LOSS_THRESH - 1);

    state_t           state_q, state_d;
    logic [23:0]      s_q, s_d;
    logic [4:0]       fill_cnt_q, fill_cnt_d;
    logic [7:0]       verify_cnt_q, verify_cnt_d;
    logic [3:0]       consec_err_q, consec_err_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [23:0]      word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             pred;

    assign pred = s_q[23] ^ s_q[22] ^ s_q[21] ^ s_q[16];

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        fill_cnt_d   = fill_cnt_q;
        verify_cnt_d = verify_cnt_q;
        consec_err_d = consec_err_q;
        bit_cnt_d    = bit_cnt_q;
        err_count_d  = err_count_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;

        if (bit_valid) begin
            case (state_q)
                SEARCH: begin
                    s_d        = {s_q[22:0], bit_in};
                    fill_cnt_d = fill_cnt_q + 5'd1;
                    if (fill_cnt_q == 5'd23) begin
                        state_d      = VERIFY;
                        verify_cnt_d = 8'd0;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[22:0], bit_in};
                    // An all-zero window predicts zeros forever; never let it lock.
                    if ((bit_in == pred) && (s_q != 24'd0)) begin
                        verify_cnt_d = verify_cnt_q + 8'd1;
                        if (verify_cnt_q == LOCK_M1) begin
                            state_d      = LOCKED;
                            bit_cnt_d    = 5'd0;
                            consec_err_d = 4'd0;
                        end
                    end else begin
                        verify_cnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    s_d = {s_q[22:0], pred};
                    if (bit_in != pred) begin
                        consec_err_d = consec_err_q + 4'd1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end else begin
                        consec_err_d = 4'd0;
                    end

                    if ((bit_in != pred) && (consec_err_q == LOSS_M1)) begin
                        state_d      = SEARCH;
                        fill_cnt_d   = 5'd0;
                        verify_cnt_d = 8'd0;
                        consec_err_d = 4'd0;
                    end else if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d    = 5'd0;
                        word_out_d   = {s_q[22:0], pred};
                        word_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEARCH;
            s_q          <= 24'd0;
            fill_cnt_q   <= 5'd0;
            verify_cnt_q <= 8'd0;
            consec_err_q <= 4'd0;
            bit_cnt_q    <= 5'd0;
            locked_q     <= 1'b0;
            err_count_q  <= '0;
            word_out_q   <= 24'd0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            fill_cnt_q   <= fill_cnt_d;
            verify_cnt_q <= verify_cnt_d;
            consec_err_q <= consec_err_d;
            bit_cnt_q    <= bit_cnt_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign locked     = locked_q;
    assign err_count  = err_count_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: a reference generator drives the stream and queues
// the expected recovered words, which a monitor compares as word_valid pulses.
module tb_lfsr_seq_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        locked;
    logic [15:0] err_count;
    logic [23:0] word_out;
    logic        word_valid;

    int          total = 0;
    int          bad = 0;
    int          n_words = 0;
    int          wcnt = 0;
    logic [23:0] gen_n;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_seq_checker #(.LOCK_CNT(32), .LOSS_THRESH(4), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .locked(locked), .err_count(err_count), .word_out(word_out), .word_valid(word_valid)
    );

    always @(negedge clk) begin
        logic [23:0] e;
        if (word_valid === 1'b1) begin
            n_words++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected got=%h expected=none", word_out);
            end else begin
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    bad++;
                    $display("FAIL word_value got=%h expected=%h", word_out, e);
                end
            end
        end
    end

    task automatic gen_step(output logic b);
        logic fb;
        fb    = gen_n[23] ^ gen_n[22] ^ gen_n[21] ^ gen_n[16];
        gen_n = {gen_n[22:0], fb};
        b     = fb;
    endtask

    task automatic step(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        bit_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // One accepted bit while locked; queues the word the checker should emit.
    task automatic lk_bit(input logic inv, input logic loss);
        logic b;
        gen_step(b);
        wcnt++;
        if (wcnt == 24) begin
            wcnt = 0;
            if (!loss) exp_q.push_back(gen_n);
        end
        step(b ^ inv, 1'b1);
    endtask

    task automatic test_reset();
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b expected=0", locked); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err got=%0d expected=0", err_count); end
        total++; if (word_out !== 24'd0) begin bad++; $display("FAIL rst_word got=%h expected=0", word_out); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b expected=0", word_valid); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lock();
        logic b;
        gen_n = 24'h00000F;
        wcnt  = 0;
        for (int i = 0; i < 56; i++) begin
            gen_step(b);
            step(b, 1'b1);
            total++;
            if (locked !== (i == 55)) begin
                bad++; $display("FAIL lock_timing bit=%0d got=%b expected=%b", i + 1, locked, (i == 55));
            end
            total++;
            if (word_valid !== 1'b0) begin
                bad++; $display("FAIL lock_wvalid bit=%0d got=%b expected=0", i + 1, word_valid);
            end
        end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL lock_err got=%0d expected=0", err_count); end
    endtask

    task automatic test_words();
        int w0;
        w0 = n_words;
        repeat (48) lk_bit(1'b0, 1'b0);
        settle();
        total++; if (n_words - w0 != 2) begin bad++; $display("FAIL words_count got=%0d expected=2", n_words - w0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL words_pending got=%0d expected=0", exp_q.size()); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL words_err got=%0d expected=0", err_count); end
    endtask

    task automatic test_single_err();
        int w0;
        w0 = n_words;
        lk_bit(1'b1, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL serr_locked got=%b expected=1", locked); end
        repeat (30) lk_bit(1'b0, 1'b0);
        settle();
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL serr_count got=%0d expected=1", err_count); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL serr_hold got=%b expected=1", locked); end
        total++; if (n_words - w0 != 1) begin bad++; $display("FAIL serr_words got=%0d expected=1", n_words - w0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL serr_pending got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_loss();
        logic b;
        for (int i = 0; i < 4; i++) begin
            lk_bit(1'b1, (i == 3));
            total++;
            if (locked !== (i < 3)) begin
                bad++; $display("FAIL loss_timing err=%0d got=%b expected=%b", i + 1, locked, (i < 3));
            end
        end
        total++; if (err_count !== 16'd5) begin bad++; $display("FAIL loss_err got=%0d expected=5", err_count); end
        for (int i = 0; i < 56; i++) begin
            gen_step(b);
            step(b, 1'b1);
            total++;
            if (locked !== (i == 55)) begin
                bad++; $display("FAIL relock_timing bit=%0d got=%b expected=%b", i + 1, locked, (i == 55));
            end
        end
        wcnt = 0;
        total++; if (err_count !== 16'd5) begin bad++; $display("FAIL relock_err got=%0d expected=5", err_count); end
        repeat (24) lk_bit(1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL relock_pending got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_no_lock();
        logic seen;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1);
            seen = seen | locked;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL zeros_locked got=%b expected=0", seen); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL zeros_err got=%0d expected=0", err_count); end
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(logic'($urandom_range(0, 1)), 1'b1);
            seen = seen | locked;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL random_locked got=%b expected=0", seen); end
    endtask

    task automatic test_sparse_and_async_reset();
        logic b;
        settle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        gen_n = 24'h00000F;
        for (int i = 0; i < 56; i++) begin
            gen_step(b);
            step(b, 1'b1);
            total++;
            if (locked !== (i == 55)) begin
                bad++; $display("FAIL sparse_lock bit=%0d got=%b expected=%b", i + 1, locked, (i == 55));
            end
            step(logic'($urandom_range(0, 1)), 1'b0);
            step(logic'($urandom_range(0, 1)), 1'b0);
            total++;
            if (locked !== (i == 55)) begin
                bad++; $display("FAIL sparse_hold bit=%0d got=%b expected=%b", i + 1, locked, (i == 55));
            end
        end
        for (int k = 0; k < 23; k++) begin
            gen_step(b);
            step(b ^ (k == 0), 1'b1);
            step(logic'($urandom_range(0, 1)), 1'b0);
            total++;
            if (word_valid !== 1'b0) begin
                bad++; $display("FAIL sparse_idle_wvalid bit=%0d got=%b expected=0", k + 1, word_valid);
            end
            step(logic'($urandom_range(0, 1)), 1'b0);
        end
        gen_step(b);
        step(b, 1'b1);
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL sparse_wvalid got=%b expected=1", word_valid); end
        total++; if (word_out !== gen_n) begin bad++; $display("FAIL sparse_word got=%h expected=%h", word_out, gen_n); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL sparse_err got=%0d expected=1", err_count); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL async_locked got=%b expected=0", locked); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL async_err got=%0d expected=0", err_count); end
        total++; if (word_out !== 24'd0) begin bad++; $display("FAIL async_word got=%h expected=0", word_out); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL async_wvalid got=%b expected=0", word_valid); end
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_words();
        test_single_err();
        test_loss();
        test_no_lock();
        test_sparse_and_async_reset();
        settle();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_pending got=%0d expected=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
